// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the RV32I hazard/forwarding controller.
// The optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
package hazard_unit_pkg;

    // Execute-stage result select encodings (result_src_e)
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // ALU operand forwarding select encodings
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // register file value read in decode
        FWD_W  = 2'b01,   // writeback-stage result
        FWD_M  = 2'b10    // memory-stage ALU result
    } fwd_sel_e;

    // A load is the only execute-stage producer whose value is not ready for
    // forwarding on the next cycle.
    function automatic logic is_load(input logic [1:0] result_src);
        return result_src == RES_MEM;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle.
// master: the hazard unit (observes decode/execute fields, drives strobes).
// slave : the pipeline datapath (supplies fields, consumes strobes).
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    // Decode / execute stage fields
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic                  regwrite_e;
    logic [1:0]            result_src_e;
    logic                  pc_src_e;

    // Forwarding selects and pipeline-register strobes
    logic [1:0]            forward_a_e;
    logic [1:0]            forward_b_e;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;

    modport master (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e,
        input  regwrite_e, result_src_e, pc_src_e,
        output forward_a_e, forward_b_e,
        output stall_f, stall_d, flush_d, flush_e
    );

    modport slave (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e,
        output regwrite_e, result_src_e, pc_src_e,
        input  forward_a_e, forward_b_e,
        input  stall_f, stall_d, flush_d, flush_e
    );

endinterface

// File: rtl/d_flipflop.sv
// Generic register with synchronous active-high clear.
module d_flipflop #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d each rising edge; Clear takes priority and loads zero
    always_ff @(posedge Clk) begin
        // NOTE: state is assigned with <= so every register samples the
        // pre-edge value of its input, independent of block ordering.
        if (Clear) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one ALU operand: the newest in-flight writer of the
// source register wins (M before W); x0 is never forwarded.
module hazard_unit_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  regwrite_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_w,
    output fwd_sel_e              fwd_sel
);

    // Priority compare against the M stage, then the W stage
    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches when neither stage matches.
        fwd_sel = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_M;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the RV32I 5-stage pipeline.
// Tracks destination register / regwrite through M and W, and drives operand
// forwarding selects, F/D stalls and D/E flushes. Defining HAZ_PERF_CNT_EN
// adds saturating load-use-stall and redirect-flush counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Clear,
    hazard_unit_if.master    hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Reject meaningless widths at elaboration
    if ((REG_ADDR_W < 1) || (CNT_W < 1)) begin : g_param_check
        $error("hazard_unit: REG_ADDR_W and CNT_W must be at least 1");
    end

    // M/W copies of the execute-stage destination
    logic [REG_ADDR_W-1:0] rd_m_d, rd_m_q;
    logic [REG_ADDR_W-1:0] rd_w_d, rd_w_q;
    logic                  regwrite_m_d, regwrite_m_q;
    logic                  regwrite_w_d, regwrite_w_q;

    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;
    logic     lwstall;

    // Advance the destination tracking one stage per cycle; flushed bubbles
    // already arrive with regwrite_e low.
    always_comb begin
        rd_m_d       = hz.rd_e;
        regwrite_m_d = hz.regwrite_e;
        rd_w_d       = rd_m_q;
        regwrite_w_d = regwrite_m_q;
    end

    d_flipflop #(.WIDTH(REG_ADDR_W)) u_rd_m (
        .Clk   (Clk),
        .Clear (Clear),
        .d     (rd_m_d),
        .q     (rd_m_q)
    );

    d_flipflop #(.WIDTH(1)) u_regwrite_m (
        .Clk   (Clk),
        .Clear (Clear),
        .d     (regwrite_m_d),
        .q     (regwrite_m_q)
    );

    d_flipflop #(.WIDTH(REG_ADDR_W)) u_rd_w (
        .Clk   (Clk),
        .Clear (Clear),
        .d     (rd_w_d),
        .q     (rd_w_q)
    );

    d_flipflop #(.WIDTH(1)) u_regwrite_w (
        .Clk   (Clk),
        .Clear (Clear),
        .d     (regwrite_w_d),
        .q     (regwrite_w_q)
    );

    hazard_unit_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_e       (hz.rs1_e),
        .rd_m       (rd_m_q),
        .regwrite_m (regwrite_m_q),
        .rd_w       (rd_w_q),
        .regwrite_w (regwrite_w_q),
        .fwd_sel    (fwd_a)
    );

    hazard_unit_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_e       (hz.rs2_e),
        .rd_m       (rd_m_q),
        .regwrite_m (regwrite_m_q),
        .rd_w       (rd_w_q),
        .regwrite_w (regwrite_w_q),
        .fwd_sel    (fwd_b)
    );

    // A load in execute whose destination feeds the instruction in decode
    // cannot be forwarded in time; x0 never creates a dependency.
    assign lwstall = is_load(hz.result_src_e) && (hz.rd_e != '0) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    // Drive forwarding and strobes; a redirect overrides a load-use stall,
    // and Clear forces every pipeline register into its flushed state.
    always_comb begin
        hz.forward_a_e = fwd_a;
        hz.forward_b_e = fwd_b;
        hz.stall_f     = lwstall && !hz.pc_src_e;
        hz.stall_d     = lwstall && !hz.pc_src_e;
        hz.flush_d     = hz.pc_src_e;
        hz.flush_e     = hz.pc_src_e || lwstall;
        if (Clear) begin
            hz.forward_a_e = FWD_RF;
            hz.forward_b_e = FWD_RF;
            hz.stall_f     = 1'b0;
            hz.stall_d     = 1'b0;
            hz.flush_d     = 1'b1;
            hz.flush_e     = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // Saturating event counts: effective stalls and redirect flushes
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (lwstall && !hz.pc_src_e && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hz.pc_src_e && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    d_flipflop #(.WIDTH(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Clear (Clear),
        .d     (stall_cnt_d),
        .q     (stall_cnt_q)
    );

    d_flipflop #(.WIDTH(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Clear (Clear),
        .d     (flush_cnt_d),
        .q     (flush_cnt_q)
    );

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of in-flight writers.
// Counter checks (including a CNT_W = 2 saturation instance) are compiled in
// when HAZ_PERF_CNT_EN is defined.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int AW    = 5;
    localparam int CNT_W = 32;

    logic Clk;
    logic Clear;

    hazard_unit_if #(.REG_ADDR_W(AW)) hif ();

    int n_checks = 0;
    int n_errors = 0;

    // Model: the two most recent execute-stage writers, index 0 = newest (M)
    logic [AW-1:0] hist_rd [2];
    logic          hist_we [2];
    longint        exp_stall_cnt;
    longint        exp_flush_cnt;
    longint        exp_stall_cnt2;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       stall_cnt2;
    logic [1:0]       flush_cnt2;

    hazard_unit_if #(.REG_ADDR_W(AW)) hif2 ();
    assign hif2.rs1_d        = hif.rs1_d;
    assign hif2.rs2_d        = hif.rs2_d;
    assign hif2.rs1_e        = hif.rs1_e;
    assign hif2.rs2_e        = hif.rs2_e;
    assign hif2.rd_e         = hif.rd_e;
    assign hif2.regwrite_e   = hif.regwrite_e;
    assign hif2.result_src_e = hif.result_src_e;
    assign hif2.pc_src_e     = hif.pc_src_e;

    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Clear     (Clear),
        .hz        (hif),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(2)) dut_narrow (
        .Clk       (Clk),
        .Clear     (Clear),
        .hz        (hif2),
        .stall_cnt (stall_cnt2),
        .flush_cnt (flush_cnt2)
    );
`else
    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Clear (Clear),
        .hz    (hif)
    );
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Load-use rule evaluated from the current inputs
    function automatic logic model_lwstall();
        return (hif.result_src_e == 2'b01) && (hif.rd_e != '0) &&
               ((hif.rd_e == hif.rs1_d) || (hif.rd_e == hif.rs2_d));
    endfunction

    // Youngest in-flight writer of rs wins: age 0 -> M (10), age 1 -> W (01)
    function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
        if (rs == '0) return 2'b00;
        for (int age = 0; age < 2; age++) begin
            if (hist_we[age] && (hist_rd[age] == rs)) return (age == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic longint sat_inc(input longint v, input int width);
        longint max_v;
        max_v = (64'sd1 <<< width) - 1;
        return (v < max_v) ? v + 1 : v;
    endfunction

    task automatic set_in(input int r1d, input int r2d, input int r1e, input int r2e,
                          input int rde, input logic we, input logic [1:0] res,
                          input logic pc);
        hif.rs1_d        = AW'(r1d);
        hif.rs2_d        = AW'(r2d);
        hif.rs1_e        = AW'(r1e);
        hif.rs2_e        = AW'(r2e);
        hif.rd_e         = AW'(rde);
        hif.regwrite_e   = we;
        hif.result_src_e = res;
        hif.pc_src_e     = pc;
    endtask

    task automatic rand_in();
        set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    endtask

    // Let combinational outputs settle, then compare everything to the model
    task automatic settle();
        logic       lw;
        logic [1:0] e_fa, e_fb;
        logic       e_st, e_fd, e_fe;
        #1;
        lw = model_lwstall();
        if (Clear) begin
            e_fa = 2'b00; e_fb = 2'b00; e_st = 1'b0; e_fd = 1'b1; e_fe = 1'b1;
        end else begin
            e_fa = model_fwd(hif.rs1_e);
            e_fb = model_fwd(hif.rs2_e);
            e_st = lw && !hif.pc_src_e;
            e_fd = hif.pc_src_e;
            e_fe = hif.pc_src_e || lw;
        end
        check("forward_a_e", 32'(hif.forward_a_e), 32'(e_fa));
        check("forward_b_e", 32'(hif.forward_b_e), 32'(e_fb));
        check("stall_f", 32'(hif.stall_f), 32'(e_st));
        check("stall_d", 32'(hif.stall_d), 32'(e_st));
        check("flush_d", 32'(hif.flush_d), 32'(e_fd));
        check("flush_e", 32'(hif.flush_e), 32'(e_fe));
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall_cnt));
        check("flush_cnt", 32'(flush_cnt), 32'(exp_flush_cnt));
        check("stall_cnt_w2", 32'(stall_cnt2), 32'(exp_stall_cnt2));
`endif
    endtask

    // Clock edge: update the model from the inputs seen at the edge
    task automatic advance();
        logic lw;
        @(posedge Clk);
        lw = model_lwstall();
        if (Clear) begin
            for (int i = 0; i < 2; i++) begin
                hist_rd[i] = '0;
                hist_we[i] = 1'b0;
            end
            exp_stall_cnt  = 0;
            exp_flush_cnt  = 0;
            exp_stall_cnt2 = 0;
        end else begin
            hist_rd[1] = hist_rd[0];
            hist_we[1] = hist_we[0];
            hist_rd[0] = hif.rd_e;
            hist_we[0] = hif.regwrite_e;
            if (lw && !hif.pc_src_e) begin
                exp_stall_cnt  = sat_inc(exp_stall_cnt, CNT_W);
                exp_stall_cnt2 = sat_inc(exp_stall_cnt2, 2);
            end
            if (hif.pc_src_e) exp_flush_cnt = sat_inc(exp_flush_cnt, CNT_W);
        end
        @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            hist_rd[i] = '0;
            hist_we[i] = 1'b0;
        end
        exp_stall_cnt  = 0;
        exp_flush_cnt  = 0;
        exp_stall_cnt2 = 0;
        Clear = 1'b1;
        set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
        @(negedge Clk);

        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            rand_in();
            settle();
            check("rst_flush_d", 32'(hif.flush_d), 32'd1);
            check("rst_flush_e", 32'(hif.flush_e), 32'd1);
            check("rst_stall_f", 32'(hif.stall_f), 32'd0);
            check("rst_fwd_a", 32'(hif.forward_a_e), 32'd0);
            advance();
        end

        // First cycle after release: nothing in flight
        Clear = 1'b0;
        set_in(1, 2, 3, 4, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("post_rst_fwd_a", 32'(hif.forward_a_e), 32'd0);
        check("post_rst_fwd_b", 32'(hif.forward_b_e), 32'd0);
        advance();

        // EX->EX forward of x5, then W forward one cycle later
        set_in(0, 0, 0, 0, 5, 1'b1, RES_ALU, 1'b0);
        settle(); advance();
        set_in(0, 0, 5, 5, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("exex_fwd_a", 32'(hif.forward_a_e), 32'h2);
        check("exex_fwd_b", 32'(hif.forward_b_e), 32'h2);
        advance();
        set_in(0, 0, 5, 0, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("w_fwd_a", 32'(hif.forward_a_e), 32'h1);
        advance();

        // Writes to x0 are never forwarded
        set_in(0, 0, 0, 0, 0, 1'b1, RES_ALU, 1'b0);
        settle(); advance();
        set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("x0_fwd_a", 32'(hif.forward_a_e), 32'h0);
        check("x0_fwd_b", 32'(hif.forward_b_e), 32'h0);
        advance();

        // M over W: two back-to-back writes of x7
        set_in(0, 0, 0, 0, 7, 1'b1, RES_ALU, 1'b0);
        settle(); advance();
        set_in(0, 0, 0, 0, 7, 1'b1, RES_PC4, 1'b0);
        settle(); advance();
        set_in(0, 0, 0, 7, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("m_over_w_fwd_b", 32'(hif.forward_b_e), 32'h2);
        advance();
        set_in(0, 0, 0, 7, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("older_only_fwd_b", 32'(hif.forward_b_e), 32'h1);
        advance();

        // Load-use on x3: one bubble, then W forward two cycles later
        set_in(0, 3, 0, 0, 3, 1'b1, RES_MEM, 1'b0);
        settle();
        check("lu_stall_f", 32'(hif.stall_f), 32'd1);
        check("lu_stall_d", 32'(hif.stall_d), 32'd1);
        check("lu_flush_e", 32'(hif.flush_e), 32'd1);
        check("lu_flush_d", 32'(hif.flush_d), 32'd0);
        advance();
        set_in(0, 3, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("lu_bubble_stall_f", 32'(hif.stall_f), 32'd0);
        advance();
        set_in(0, 0, 0, 3, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("lu_w_fwd_b", 32'(hif.forward_b_e), 32'h1);
        advance();

        // Taken branch, then redirect coinciding with a load-use
        set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b1);
        settle();
        check("br_flush_d", 32'(hif.flush_d), 32'd1);
        check("br_flush_e", 32'(hif.flush_e), 32'd1);
        check("br_stall_f", 32'(hif.stall_f), 32'd0);
        advance();
        set_in(4, 0, 0, 0, 4, 1'b1, RES_MEM, 1'b1);
        settle();
        check("br_lu_stall_d", 32'(hif.stall_d), 32'd0);
        check("br_lu_flush_d", 32'(hif.flush_d), 32'd1);
        check("br_lu_flush_e", 32'(hif.flush_e), 32'd1);
        advance();

`ifdef HAZ_PERF_CNT_EN
        // Three stalls and two redirects from a cleared state
        Clear = 1'b1;
        set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
        settle(); advance();
        Clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(6, 0, 0, 0, 6, 1'b1, RES_MEM, 1'b0);
            settle(); advance();
            set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
            settle(); advance();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b1);
            settle(); advance();
        end
        set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("cnt_stall_3", 32'(stall_cnt), 32'd3);
        check("cnt_flush_2", 32'(flush_cnt), 32'd2);
        Clear = 1'b1;
        advance();
        Clear = 1'b0;
        settle();
        check("cnt_stall_clr", 32'(stall_cnt), 32'd0);
        check("cnt_flush_clr", 32'(flush_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 2, 0, 0, 2, 1'b1, RES_MEM, 1'b0);
            settle(); advance();
        end
        set_in(0, 0, 0, 0, 0, 1'b0, RES_ALU, 1'b0);
        settle();
        check("cnt_w2_saturate", 32'(stall_cnt2), 32'd3);
        check("cnt_stall_5", 32'(stall_cnt), 32'd5);
        advance();
`endif

        // Random traffic with occasional Clear
        for (int i = 0; i < 400; i++) begin
            Clear = ($urandom_range(0, 31) == 0);
            rand_in();
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard and forwarding controller for the RV32I 5-stage pipeline.
- Initiator side of the D/E control register: it generates the Clear (flush) and stall strobes that pipeline registers consume.
- Reads execute-stage control outputs (regwrite_e, result_src_e, branch/jump resolution) and keeps its own M/W-stage copies of destination register and regwrite.
- From these it drives operand forwarding selects, F/D stalls and D/E flushes.

Parameters:
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, width of the performance counters (used only with HAZ_PERF_CNT_EN)

Ports:
- Clk  in  1  clock, rising edge
- Clear  in  1  synchronous active-high reset
- rs1_d  in  REG_ADDR_W  source register 1 of instruction in decode
- rs2_d  in  REG_ADDR_W  source register 2 of instruction in decode
- rs1_e  in  REG_ADDR_W  source register 1 of instruction in execute
- rs2_e  in  REG_ADDR_W  source register 2 of instruction in execute
- rd_e  in  REG_ADDR_W  destination register of instruction in execute
- regwrite_e  in  1  execute-stage regwrite
- result_src_e  in  2  execute-stage result select; 2'b01 = load data
- pc_src_e  in  1  taken branch / jal / jalr resolved in execute
- forward_a_e  out  2  ALU operand A select: 00 regfile, 10 M-stage ALU result, 01 W-stage result
- forward_b_e  out  2  ALU operand B select, same encoding
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  Clear for F/D register
- flush_e  out  1  Clear for D/E register
- stall_cnt  out  CNT_W  load-use stall cycles (HAZ_PERF_CNT_EN only)
- flush_cnt  out  CNT_W  redirect flush events (HAZ_PERF_CNT_EN only)

Behaviour:
- Clock and reset: one clock, Clk. Clear is synchronous and active-high.
- State registers, updated each rising edge:
  - rd_m <= rd_e, regwrite_m <= regwrite_e
  - rd_w <= rd_m, regwrite_w <= regwrite_m
  - The D/E flush already zeroes regwrite_e, so bubbles propagate as regwrite 0.
- Reset:
  - While Clear is high at an edge, rd_m, rd_w, regwrite_m, regwrite_w and the counters load 0.
  - While Clear is high, outputs are forced combinationally: forward_* = 00, stall_f = stall_d = 0, flush_d = flush_e = 1.
  - Reset mid-stall simply drops the stall in the same cycle.
- Forwarding (combinational, 0-cycle latency from registered state), per operand X in {1, 2}:
  - 10 if regwrite_m and rd_m != 0 and rd_m == rsX_e
  - else 01 if regwrite_w and rd_w != 0 and rd_w == rsX_e
  - else 00
  - M has priority over W when both match.
- Load-use hazard: lwstall = (result_src_e == 2'b01) and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d). Its effects:
  - stall_f = stall_d = lwstall
  - flush_e includes lwstall
  - Exactly one bubble is inserted per load-use pair. The next cycle the load is in M, lwstall deasserts and forwarding resolves the dependency via W on the following cycle.
- Control hazard:
  - flush_d = pc_src_e
  - flush_e = pc_src_e or lwstall
- Simultaneous events:
  - pc_src_e and lwstall are mutually exclusive by decode. If both are high, the redirect wins: stall_f = stall_d = 0 and flush_d = flush_e = 1.
- x0: never forwarded, never causes a stall.
- Unused rs fields (e.g. U/J type) may cause spurious stalls; this is permitted and costs performance only.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with lwstall and not pc_src_e.
  - flush_cnt increments on every cycle with pc_src_e.
  - Both saturate at all-ones and reset to 0 on Clear.
- Undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Shared package/header: result_src encodings (RES_ALU = 00, RES_MEM = 01, RES_PC4 = 10, RES_IMM = 11) and forward-select encodings (FWD_RF = 00, FWD_W = 01, FWD_M = 10).
- One natural sub-module: fwd_sel, which compares one rs against (rd_m, regwrite_m) and (rd_w, regwrite_w) and returns the 2-bit select. It is instantiated twice.
- The M/W tracking registers reuse d_flipflop.

Test Plan:
- Reset: hold Clear 2 cycles with random inputs -> flush_d = flush_e = 1, stall_* = 0, forward_* = 00. First cycle after release with regwrite_e = 0 -> all forward_* = 00.
- EX→EX forward: regwrite_e = 1, rd_e = 5, then next cycle rs1_e = 5, rs2_e = 5 -> forward_a_e = forward_b_e = 10. Same with rd_e = 0 -> 00.
- M-over-W priority: rd = 7 written by two consecutive instructions, then rs2_e = 7 -> forward_b_e = 10. If only the older write is present -> 01.
- Load-use: result_src_e = 01, rd_e = 3, rs2_d = 3 -> stall_f = stall_d = flush_e = 1, flush_d = 0 for exactly 1 cycle. Two cycles later rs2_e = 3 -> forward_b_e = 01.
- Branch taken: pc_src_e = 1 for 1 cycle -> flush_d = flush_e = 1, stalls 0. With lwstall forced high simultaneously -> stalls 0, flushes 1.
- HAZ_PERF_CNT_EN: 3 load-use stalls and 2 redirects -> stall_cnt = 3, flush_cnt = 2. Mid-run Clear -> both 0. With CNT_W = 2 and 5 stalls -> stall_cnt saturates at 3.
